// File: rtl/weight_loader_pkg.sv
// -----------------------------------------------------------------------------
// weight_loader_pkg
//  Shared definitions for the weight loader: FSM state encoding and the bit
//  positions of the header word fields.
//  Header word layout:
//   [HDR_IDX_LSB +: neuronWidth]       target neuron index
//   [HDR_LAYER_MSB:HDR_LAYER_LSB]      target layer id
//  The neuron field must not reach into the layer field, so neuronWidth <= 8.
// -----------------------------------------------------------------------------
package weight_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // waiting for a header word
      ST_LOAD = 2'd1,   // writing weights of an addressed neuron
      ST_SKIP = 2'd2,   // consuming weights of a packet not meant for us
      ST_DONE = 2'd3    // one-cycle bookkeeping after a complete load
   } state_e;

   localparam int HDR_IDX_LSB   = 0;
   localparam int HDR_LAYER_LSB = 8;
   localparam int HDR_LAYER_MSB = 15;
   localparam int HDR_LAYER_W   = HDR_LAYER_MSB - HDR_LAYER_LSB + 1;

endpackage : weight_loader_pkg

// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
//  Write-side front end for the per-neuron weight memories of one layer.
//  Consumes a valid/ready word stream made of packets: one header word
//  (layer id + neuron index) followed by numWeight weight words, the last one
//  flagged with s_last. Weights addressed to this layer are turned into
//  write strobes (wen/wadd/win) plus a neuron select (wsel); the layer wrapper
//  gates each memory's write enable with wsel == n.
//
//  Ports
//   clk         clock, everything on the rising edge
//   rst_n       synchronous active-low reset
//   s_valid     stream word valid
//   s_ready     loader can accept a word (registered)
//   s_data      header or weight word
//   s_last      final word of a packet
//   wen         write strobe, one cycle after the word was accepted
//   wadd        weight address within the neuron
//   win         weight data
//   wsel        target neuron index
//   load_done   one-cycle pulse when a neuron has been completely written
//   loaded      bit n set once neuron n has been completely written
//   all_loaded  every neuron of the layer is loaded
//   err_len     sticky until next header: s_last was in the wrong place
//   err_tgt     sticky until next header: neuron index out of range
// -----------------------------------------------------------------------------
module weight_loader
   import weight_loader_pkg::*;
#(
   parameter int dataWidth    = 16,
   parameter int addressWidth = 10,
   parameter int numWeight    = 3,
   parameter int numNeuron    = 5,
   parameter int layerNo      = 1,
   parameter int neuronWidth  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [dataWidth-1:0]    s_data,
   input  logic                    s_last,
   output logic                    wen,
   output logic [addressWidth-1:0] wadd,
   output logic [dataWidth-1:0]    win,
   output logic [neuronWidth-1:0]  wsel,
   output logic                    load_done,
   output logic [numNeuron-1:0]    loaded,
   output logic                    all_loaded,
   output logic                    err_len,
   output logic                    err_tgt
);

   state_e                  state_q,     state_d;
   logic                    s_ready_q,   s_ready_d;
   logic                    wen_q,       wen_d;
   logic [addressWidth-1:0] wadd_q,      wadd_d;
   logic [dataWidth-1:0]    win_q,       win_d;
   logic [neuronWidth-1:0]  wsel_q,      wsel_d;
   logic [neuronWidth-1:0]  idx_q,       idx_d;
   logic [addressWidth-1:0] cnt_q,       cnt_d;
   logic                    load_done_q, load_done_d;
   logic [numNeuron-1:0]    loaded_q,    loaded_d;
   logic                    err_len_q,   err_len_d;
   logic                    err_tgt_q,   err_tgt_d;

   logic                    accept;
   logic [neuronWidth-1:0]  hdr_idx;
   logic [HDR_LAYER_W-1:0]  hdr_layer;
   logic                    layer_hit;
   logic                    idx_ok;
   logic                    last_word;

   assign accept    = s_valid && s_ready_q;
   assign hdr_idx   = s_data[HDR_IDX_LSB +: neuronWidth];
   assign hdr_layer = s_data[HDR_LAYER_MSB:HDR_LAYER_LSB];
   assign layer_hit = (hdr_layer == HDR_LAYER_W'(layerNo));
   assign idx_ok    = (int'(hdr_idx) < numNeuron);
   assign last_word = (cnt_q == addressWidth'(numWeight - 1));

   always_comb begin
      // NOTE: every next-state signal gets a default before the case; a path
      // that leaves one unassigned would infer a latch.
      state_d     = state_q;
      wen_d       = 1'b0;
      wadd_d      = wadd_q;
      win_d       = win_q;
      wsel_d      = wsel_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      load_done_d = 1'b0;
      loaded_d    = loaded_q;
      err_len_d   = err_len_q;
      err_tgt_d   = err_tgt_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               // A new header starts a fresh error report.
               err_len_d = 1'b0;
               err_tgt_d = layer_hit && !idx_ok;
               idx_d     = hdr_idx;
               cnt_d     = '0;
               if (s_last) begin
                  // Header-only packet: nothing to consume, stay here.
                  err_len_d = 1'b1;
               end else if (layer_hit && idx_ok) begin
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_SKIP;
               end
            end
         end

         ST_LOAD, ST_SKIP: begin
            if (accept) begin
               if (state_q == ST_LOAD) begin
                  wen_d  = 1'b1;
                  wadd_d = cnt_q;
                  win_d  = s_data;
                  wsel_d = idx_q;
               end
               if (last_word) begin
                  // Packet length is fixed: the final weight ends it even if
                  // s_last is missing, so following words parse as a header.
                  cnt_d = '0;
                  if (!s_last) err_len_d = 1'b1;
                  state_d = (state_q == ST_LOAD) ? ST_DONE : ST_IDLE;
               end else if (s_last) begin
                  // Short packet: abandon it, the neuron is not marked loaded.
                  cnt_d     = '0;
                  err_len_d = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         ST_DONE: begin
            load_done_d = 1'b1;
            for (int n = 0; n < numNeuron; n++) begin
               if (int'(idx_q) == n) loaded_d[n] = 1'b1;
            end
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // Registered ready: low exactly for the cycle spent in DONE.
   assign s_ready_d = (state_d != ST_DONE);

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         s_ready_q   <= 1'b0;
         wen_q       <= 1'b0;
         wadd_q      <= '0;
         win_q       <= '0;
         wsel_q      <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         load_done_q <= 1'b0;
         loaded_q    <= '0;
         err_len_q   <= 1'b0;
         err_tgt_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_ready_q   <= s_ready_d;
         wen_q       <= wen_d;
         wadd_q      <= wadd_d;
         win_q       <= win_d;
         wsel_q      <= wsel_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         load_done_q <= load_done_d;
         loaded_q    <= loaded_d;
         err_len_q   <= err_len_d;
         err_tgt_q   <= err_tgt_d;
      end
   end

   assign s_ready    = s_ready_q;
   assign wen        = wen_q;
   assign wadd       = wadd_q;
   assign win        = win_q;
   assign wsel       = wsel_q;
   assign load_done  = load_done_q;
   assign loaded     = loaded_q;
   assign all_loaded = &loaded_q;
   assign err_len    = err_len_q;
   assign err_tgt    = err_tgt_q;

endmodule : weight_loader

// File: tb/tb_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_loader
//  Drives packets into weight_loader and compares the resulting write stream,
//  status flags and a bench-side copy of the weight memories against a
//  packet-level reference model.
// -----------------------------------------------------------------------------
module tb_weight_loader;

   localparam int DW    = 16;
   localparam int AW    = 10;
   localparam int NW    = 3;
   localparam int NN    = 5;
   localparam int LAYER = 1;
   localparam int NWID  = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            s_valid;
   logic            s_ready;
   logic [DW-1:0]   s_data;
   logic            s_last;
   logic            wen;
   logic [AW-1:0]   wadd;
   logic [DW-1:0]   win;
   logic [NWID-1:0] wsel;
   logic            load_done;
   logic [NN-1:0]   loaded;
   logic            all_loaded;
   logic            err_len;
   logic            err_tgt;

   always #5 clk = ~clk;

   weight_loader #(
      .dataWidth(DW), .addressWidth(AW), .numWeight(NW),
      .numNeuron(NN), .layerNo(LAYER), .neuronWidth(NWID)
   ) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .wen(wen), .wadd(wadd), .win(win),
      .wsel(wsel), .load_done(load_done), .loaded(loaded),
      .all_loaded(all_loaded), .err_len(err_len), .err_tgt(err_tgt)
   );

   typedef struct packed {
      logic [NWID-1:0] sel;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   data;
   } wr_t;

   wr_t           got_q[$];
   wr_t           exp_q[$];
   logic [DW-1:0] fixed_q[$];
   logic [DW-1:0] dut_mem [NN][NW];
   logic [DW-1:0] exp_mem [NN][NW];
   logic [NN-1:0] exp_loaded;
   logic          exp_err_len;
   logic          exp_err_tgt;
   int            exp_done;
   int            done_seen;
   int            errors;
   int            checks;

   // Bench-side weight memories: each neuron's memory writes when wen && wsel==n.
   always @(negedge clk) begin : monitor
      int si;
      int ai;
      if (wen) begin
         got_q.push_back('{sel: wsel, addr: wadd, data: win});
         si = int'(wsel);
         ai = int'(wadd);
         if (si < NN && ai < NW) dut_mem[si][ai] = win;
      end
      if (load_done) done_seen++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_word(input logic [DW-1:0] d, input logic last, input int gap);
      bit taken = 1'b0;
      s_valid = 1'b0;
      repeat (gap) @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      for (int t = 0; t < 20 && !taken; t++) begin
         if (s_ready) begin
            @(posedge clk);
            taken = 1'b1;
         end
         @(negedge clk);
      end
      if (!taken) check("ready_timeout", 64'(s_ready), 64'd1);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Reference model at packet level: a packet addressed to an in-range
   // neuron of this layer writes weight i to address i; a full-length packet
   // marks the neuron loaded; s_last anywhere but on the final weight is a
   // length error.
   task automatic run_packet(input logic [15:0] hdr, input logic hdr_last,
                             input int nw, input int last_at, input int max_gap);
      int            layer;
      int            idx;
      bit            target;
      logic [DW-1:0] d;
      layer  = int'(hdr[15:8]);
      idx    = int'(hdr[7:0]);
      target = (layer == LAYER) && (idx < NN);
      exp_err_len = 1'b0;
      exp_err_tgt = (layer == LAYER) && (idx >= NN);
      send_word(DW'(hdr), hdr_last, $urandom_range(max_gap, 0));
      if (hdr_last) begin
         exp_err_len = 1'b1;
      end else begin
         for (int i = 0; i < nw; i++) begin
            if (fixed_q.size() != 0) d = fixed_q.pop_front();
            else                     d = DW'($urandom);
            send_word(d, (i == last_at), $urandom_range(max_gap, 0));
            if (target) begin
               exp_q.push_back('{sel: NWID'(idx), addr: AW'(i), data: d});
               exp_mem[idx][i] = d;
            end
         end
         if (nw == NW) begin
            if (last_at != NW - 1) exp_err_len = 1'b1;
            if (target) begin
               exp_loaded[idx] = 1'b1;
               exp_done++;
            end
         end else begin
            exp_err_len = 1'b1;
         end
      end
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check({tag, "_write"}, 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_all(input string tag);
      repeat (4) @(negedge clk);
      check_writes(tag);
      check({tag, "_loaded"},     64'(loaded),     64'(exp_loaded));
      check({tag, "_all_loaded"}, 64'(all_loaded), 64'(&exp_loaded));
      check({tag, "_err_len"},    64'(err_len),    64'(exp_err_len));
      check({tag, "_err_tgt"},    64'(err_tgt),    64'(exp_err_tgt));
      check({tag, "_done_cnt"},   64'(done_seen),  64'(exp_done));
      check({tag, "_ready"},      64'(s_ready),    64'd1);
      check({tag, "_wen_idle"},   64'(wen),        64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_ready"},    64'(s_ready),    64'd0);
      check({tag, "_wen"},        64'(wen),        64'd0);
      check({tag, "_wadd"},       64'(wadd),       64'd0);
      check({tag, "_win"},        64'(win),        64'd0);
      check({tag, "_wsel"},       64'(wsel),       64'd0);
      check({tag, "_load_done"},  64'(load_done),  64'd0);
      check({tag, "_loaded"},     64'(loaded),     64'd0);
      check({tag, "_all_loaded"}, 64'(all_loaded), 64'd0);
      check({tag, "_err_len"},    64'(err_len),    64'd0);
      check({tag, "_err_tgt"},    64'(err_tgt),    64'd0);
   endtask

   initial begin
      errors      = 0;
      checks      = 0;
      done_seen   = 0;
      exp_done    = 0;
      exp_loaded  = '0;
      exp_err_len = 1'b0;
      exp_err_tgt = 1'b0;
      for (int n = 0; n < NN; n++)
         for (int a = 0; a < NW; a++) begin
            dut_mem[n][a] = '0;
            exp_mem[n][a] = '0;
         end
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // 1: directed load of layer 1 neuron 2
      fixed_q = '{16'h0011, 16'h0022, 16'h0033};
      run_packet(16'h0102, 1'b0, NW, NW - 1, 0);
      check_all("t1_load_n2");

      // 2: other layer is skipped silently
      run_packet(16'h0300, 1'b0, NW, NW - 1, 1);
      check_all("t2_other_layer");

      // 3: out-of-range neuron, then a good header clears the flag
      run_packet(16'h0107, 1'b0, NW, NW - 1, 1);
      check_all("t3_bad_idx");
      run_packet(16'h0100, 1'b0, NW, NW - 1, 0);
      check_all("t3_good_after");

      // 4: early s_last, header-only packet, missing s_last
      run_packet(16'h0103, 1'b0, 2, 1, 0);
      check_all("t4_short");
      run_packet(16'h0104, 1'b1, 0, -1, 0);
      check_all("t4_hdr_last");
      run_packet(16'h0103, 1'b0, NW, -1, 0);
      check_all("t4_no_last");

      // 5: every neuron with random gaps, then overwrite one already loaded
      for (int n = 0; n < NN; n++) begin
         run_packet(16'h0100 | 16'(n), 1'b0, NW, NW - 1, 3);
         check_all("t5_load");
      end
      run_packet(16'h0102, 1'b0, NW, NW - 1, 2);
      check_all("t5_reload");
      for (int n = 0; n < NN; n++)
         for (int a = 0; a < NW; a++)
            check("t5_readback", 64'(dut_mem[n][a]), 64'(exp_mem[n][a]));

      // 6: reset in the middle of a load
      send_word(16'h0101, 1'b0, 0);
      fixed_q = '{16'hBEEF};
      exp_q.push_back('{sel: NWID'(1), addr: AW'(0), data: 16'hBEEF});
      send_word(fixed_q.pop_front(), 1'b0, 0);
      exp_mem[1][0] = 16'hBEEF;
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("t6_reset");
      check_writes("t6_pre_reset");
      exp_loaded  = '0;
      exp_err_len = 1'b0;
      exp_err_tgt = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      run_packet(16'h0104, 1'b0, NW, NW - 1, 1);
      check_all("t6_after_reset");
      check("t6_mem_n1", 64'(dut_mem[1][0]), 64'(exp_mem[1][0]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_weight_loader
